// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_iter
//  Purpose  : Iterative RV32M multiply/divide unit for the EX stage.
//             Radix-2 shift-add multiply, restoring divide, one bit per
//             cycle, with a sign-fix cycle and a one-cycle result pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_iter #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] op_a_i,
   input  logic [XLEN-1:0] op_b_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            result_valid_o,
   output logic [XLEN-1:0] result_o
);

   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_run  = 2'd1;
   localparam logic [1:0] c_st_fix  = 2'd2;
   localparam logic [1:0] c_st_done = 2'd3;

   localparam logic [XLEN-1:0] c_min_neg = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [4:0]      c_last    = 5'd31;

   logic [1:0]        r_state;
   logic [4:0]        r_count;
   logic [2:0]        r_f3;
   logic              r_sign_a;
   logic              r_sign_b;
   // Multiply: shifting multiplicand. Divide: low half is dividend/quotient.
   logic [2*XLEN-1:0] r_opa;
   // Multiply: shifting multiplier. Divide: divisor magnitude.
   logic [XLEN-1:0]   r_opb;
   // Multiply: product accumulator. Divide: low 33 bits are partial remainder.
   logic [2*XLEN-1:0] r_acc;
   logic [XLEN-1:0]   r_result;

   // Operand decode for the instruction currently presented
   logic            w_a_signed;
   logic            w_b_signed;
   logic            w_sign_a;
   logic            w_sign_b;
   logic [XLEN-1:0] w_mag_a;
   logic [XLEN-1:0] w_mag_b;
   logic            w_div_zero;
   logic            w_div_ovf;
   logic [XLEN-1:0] w_special_res;

   assign w_a_signed = funct3_i[2] ? ~funct3_i[0] : (funct3_i[1:0] != 2'b11);
   assign w_b_signed = funct3_i[2] ? ~funct3_i[0] : ~funct3_i[1];
   assign w_sign_a   = w_a_signed & op_a_i[XLEN-1];
   assign w_sign_b   = w_b_signed & op_b_i[XLEN-1];
   assign w_mag_a    = w_sign_a ? (-op_a_i) : op_a_i;
   assign w_mag_b    = w_sign_b ? (-op_b_i) : op_b_i;

   // Divide special cases resolved at acceptance without iterating
   assign w_div_zero = funct3_i[2] & (op_b_i == '0);
   assign w_div_ovf  = funct3_i[2] & ~funct3_i[0] &
                       (op_a_i == c_min_neg) & (op_b_i == '1);
   assign w_special_res = w_div_zero ? (funct3_i[1] ? op_a_i : '1)
                                     : (funct3_i[1] ? '0 : c_min_neg);

   // Restoring-divide step: shift in next dividend bit, trial subtract
   logic [XLEN:0] w_shift;
   logic [XLEN:0] w_diff;
   logic          w_qbit;

   assign w_shift = {r_acc[XLEN-1:0], r_opa[XLEN-1]};
   assign w_diff  = w_shift - {1'b0, r_opb};
   assign w_qbit  = ~w_diff[XLEN];

   // Sign correction and result selection for the FIX cycle
   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0]   w_quo;
   logic [XLEN-1:0]   w_rem;
   logic [XLEN-1:0]   w_fix_res;

   assign w_prod = (r_sign_a ^ r_sign_b) ? (-r_acc) : r_acc;
   assign w_quo  = (r_sign_a ^ r_sign_b) ? (-r_opa[XLEN-1:0]) : r_opa[XLEN-1:0];
   assign w_rem  = r_sign_a ? (-r_acc[XLEN-1:0]) : r_acc[XLEN-1:0];
   assign w_fix_res = r_f3[2]            ? (r_f3[1] ? w_rem : w_quo) :
                      (r_f3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

   // Sequencer: accept, iterate 32 steps, fix signs, present result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= c_st_idle;
         r_count  <= '0;
         r_f3     <= '0;
         r_sign_a <= 1'b0;
         r_sign_b <= 1'b0;
         r_opa    <= '0;
         r_opb    <= '0;
         r_acc    <= '0;
         r_result <= '0;
      end else if (flush_i) begin
         r_state <= c_st_idle;
         r_count <= '0;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (start_i) begin
                  r_f3     <= funct3_i;
                  r_sign_a <= w_sign_a;
                  r_sign_b <= w_sign_b;
                  r_opa    <= {{XLEN{1'b0}}, w_mag_a};
                  r_opb    <= w_mag_b;
                  r_acc    <= '0;
                  r_count  <= '0;
                  if (w_div_zero | w_div_ovf) begin
                     r_result <= w_special_res;
                     r_state  <= c_st_done;
                  end else begin
                     r_state  <= c_st_run;
                  end
               end
            end
            c_st_run: begin
               if (r_f3[2]) begin
                  r_acc <= {{(XLEN-1){1'b0}}, (w_qbit ? w_diff : w_shift)};
                  r_opa <= {{XLEN{1'b0}}, r_opa[XLEN-2:0], w_qbit};
               end else begin
                  r_acc <= r_acc + (r_opb[0] ? r_opa : '0);
                  r_opa <= r_opa << 1;
                  r_opb <= r_opb >> 1;
               end
               r_count <= r_count + 5'd1;
               if (r_count == c_last) begin
                  r_state <= c_st_fix;
               end
            end
            c_st_fix: begin
               r_result <= w_fix_res;
               r_state  <= c_st_done;
            end
            default: begin
               r_state <= c_st_idle;
            end
         endcase
      end
   end

   assign stall_o = ~flush_i & (((r_state == c_st_idle) & start_i) |
                                (r_state == c_st_run) | (r_state == c_st_fix));
   assign result_valid_o = (r_state == c_st_done) & ~flush_i;
   assign result_o       = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_iter
//  Purpose  : Scoreboard bench for muldiv_iter with directed vectors.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_iter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start_i = 1'b0;
   logic        flush_i = 1'b0;
   logic [2:0]  funct3_i = 3'd0;
   logic [31:0] op_a_i = 32'd0;
   logic [31:0] op_b_i = 32'd0;
   logic        stall_o;
   logic        result_valid_o;
   logic [31:0] result_o;

   muldiv_iter #(.XLEN(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .start_i        (start_i),
      .funct3_i       (funct3_i),
      .op_a_i         (op_a_i),
      .op_b_i         (op_b_i),
      .flush_i        (flush_i),
      .stall_o        (stall_o),
      .result_valid_o (result_valid_o),
      .result_o       (result_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      int          issue;
      int          lat;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: pop and compare every presented result
   always @(negedge clk) begin : mon
      exp_t e;
      if (result_valid_o === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("unexpected_valid", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check({e.name, "_result"}, result_o, e.res);
            check({e.name, "_latency"}, 32'(cyc - e.issue), 32'(e.lat));
         end
      end
   end

   // Present one instruction starting at posedge+1, hold through DONE
   task automatic run_op(input string name, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat);
      bit stall_ok;
      stall_ok = 1'b1;
      funct3_i = f3;
      op_a_i   = a;
      op_b_i   = b;
      start_i  = 1'b1;
      sb_q.push_back('{exp, cyc, lat, name});
      for (int k = 0; k <= lat; k++) begin
         @(negedge clk);
         if (stall_o !== (k < lat)) stall_ok = 1'b0;
      end
      check({name, "_stall"}, 32'(stall_ok), 32'd1);
      @(posedge clk);
      #1;
      start_i = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      #1 rst = 1'b1;
      #1;
      check("reset_valid", 32'(result_valid_o), 32'd0);
      check("reset_result", result_o, 32'd0);
      check("reset_stall", 32'(stall_o), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;

      // Multiply family
      run_op("mul_7_m3",    3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 34);
      run_op("mulh_m1_m1",  3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34);
      run_op("mulhsu_m1",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
      run_op("mulhu_max",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
      run_op("mul_shift",   3'b000, 32'h12345678, 32'h00000010, 32'h23456780, 34);
      run_op("mulhu_2",     3'b011, 32'h80000000, 32'h00000004, 32'h00000002, 34);
      run_op("mul_m8_m8",   3'b000, 32'hFFFFFFF8, 32'hFFFFFFF8, 32'h00000040, 34);

      // Divide family
      run_op("div_m7_2",    3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 34);
      run_op("rem_m7_2",    3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 34);
      run_op("divu_big",    3'b101, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, 34);
      run_op("remu_big",    3'b111, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 34);
      run_op("div_100_m7",  3'b100, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 34);
      run_op("rem_100_m7",  3'b110, 32'd100,      32'hFFFFFFF9, 32'h00000002, 34);

      // Special cases
      run_op("div_by0",     3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
      run_op("divu_by0",    3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
      run_op("rem_by0",     3'b110, 32'd5,        32'd0,        32'h00000005, 1);
      run_op("remu_by0",    3'b111, 32'd5,        32'd0,        32'h00000005, 1);
      run_op("div_ovf",     3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
      run_op("rem_ovf",     3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

      // Flush a DIV in its tenth cycle, then a MUL right behind it
      funct3_i = 3'b100;
      op_a_i   = 32'd100;
      op_b_i   = 32'd7;
      start_i  = 1'b1;
      repeat (10) @(posedge clk);
      #1 flush_i = 1'b1;
      @(negedge clk);
      check("flush_stall", 32'(stall_o), 32'd0);
      check("flush_valid", 32'(result_valid_o), 32'd0);
      @(posedge clk);
      #1 flush_i = 1'b0;
      run_op("mul_after_flush", 3'b000, 32'd1000, 32'd1000, 32'h000F4240, 34);

      // Asynchronous reset in the middle of RUN
      funct3_i = 3'b000;
      op_a_i   = 32'd3;
      op_b_i   = 32'd5;
      start_i  = 1'b1;
      repeat (20) @(posedge clk);
      #3;
      start_i = 1'b0;
      rst     = 1'b1;
      #1;
      check("midrun_rst_valid", 32'(result_valid_o), 32'd0);
      check("midrun_rst_result", result_o, 32'd0);
      check("midrun_rst_stall", 32'(stall_o), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      run_op("mul_after_rst", 3'b000, 32'd12345, 32'hFFFFFFFF, 32'hFFFFCFC7, 34);

      repeat (5) @(posedge clk);
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
